// File: rtl/ex_mem_if.sv
// EX -> MEM stage bundle: execute-stage inputs, memory-stage outputs,
// branch redirect and overflow-trap signalling.
interface ex_mem_if #(
  parameter int DW = 32,
  parameter int RW = 5
) ();
  logic          ex_valid;
  logic [DW-1:0] ex_alu_result;
  logic          ex_zero;
  logic          ex_overflow;
  logic [DW-1:0] ex_rt_data;
  logic [RW-1:0] ex_write_reg;
  logic [DW-1:0] ex_pc_plus4;
  logic [DW-1:0] ex_branch_target;
  logic          ex_reg_write;
  logic          ex_mem_read;
  logic          ex_mem_write;
  logic          ex_mem_to_reg;
  logic          ex_branch;
  logic          ex_branch_ne;
  logic          ex_trap_ovf;
  logic          mem_stall;
  logic          trap_ack;
  logic          ex_ready;
  logic          mem_valid;
  logic          mem_reg_write;
  logic          mem_mem_read;
  logic          mem_mem_write;
  logic          mem_mem_to_reg;
  logic [DW-1:0] mem_alu_result;
  logic [DW-1:0] mem_write_data;
  logic [RW-1:0] mem_write_reg;
  logic          pc_src;
  logic [DW-1:0] branch_pc;
  logic          flush_upstream;
  logic          ovf_exception;
  logic [DW-1:0] epc;
  logic [31:0]   retire_count;

  modport master (
    output ex_valid, ex_alu_result, ex_zero, ex_overflow,
    output ex_rt_data, ex_write_reg, ex_pc_plus4,
    output ex_branch_target, ex_reg_write, ex_mem_read,
    output ex_mem_write, ex_mem_to_reg, ex_branch,
    output ex_branch_ne, ex_trap_ovf, mem_stall, trap_ack,
    input  ex_ready, mem_valid, mem_reg_write, mem_mem_read,
    input  mem_mem_write, mem_mem_to_reg, mem_alu_result,
    input  mem_write_data, mem_write_reg, pc_src, branch_pc,
    input  flush_upstream, ovf_exception, epc, retire_count
  );

  modport slave (
    input  ex_valid, ex_alu_result, ex_zero, ex_overflow,
    input  ex_rt_data, ex_write_reg, ex_pc_plus4,
    input  ex_branch_target, ex_reg_write, ex_mem_read,
    input  ex_mem_write, ex_mem_to_reg, ex_branch,
    input  ex_branch_ne, ex_trap_ovf, mem_stall, trap_ack,
    output ex_ready, mem_valid, mem_reg_write, mem_mem_read,
    output mem_mem_write, mem_mem_to_reg, mem_alu_result,
    output mem_write_data, mem_write_reg, pc_src, branch_pc,
    output flush_upstream, ovf_exception, epc, retire_count
  );
endinterface

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: branch resolution, overflow trap,
// and retired-instruction counter.
module ex_mem_reg #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input logic     clk,
  input logic     rst_n,
  ex_mem_if.slave bus
);

  typedef enum logic {RUN, TRAP} state_t;

  state_t        state_q;
  logic          valid_q;
  logic          reg_write_q;
  logic          mem_read_q;
  logic          mem_write_q;
  logic          mem_to_reg_q;
  logic [DW-1:0] alu_q;
  logic [DW-1:0] wdata_q;
  logic [RW-1:0] wreg_q;
  logic          pc_src_q;
  logic [DW-1:0] branch_pc_q;
  logic          flush_q;
  logic          ovf_q;
  logic [DW-1:0] epc_q;
  logic [31:0]   retire_q;

  logic accept;
  logic taken;
  logic ovf_trap;

  // Accept/branch/trap qualification for the current EX slot.
  always_comb begin
    accept   = bus.ex_valid & ~bus.mem_stall & (state_q == RUN);
    taken    = bus.ex_branch & (bus.ex_zero ^ bus.ex_branch_ne);
    ovf_trap = bus.ex_trap_ovf & bus.ex_overflow & ~bus.ex_branch;
  end

  // Stage state, MEM-side fields, redirect and trap bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= RUN;
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_q        <= '0;
      wdata_q      <= '0;
      wreg_q       <= '0;
      pc_src_q     <= 1'b0;
      branch_pc_q  <= '0;
      flush_q      <= 1'b0;
      ovf_q        <= 1'b0;
      epc_q        <= '0;
      retire_q     <= '0;
    end else begin
      pc_src_q <= 1'b0;
      flush_q  <= 1'b0;
      if (!bus.mem_stall) begin
        if (accept && bus.ex_branch) begin
          valid_q      <= 1'b1;
          reg_write_q  <= 1'b0;
          mem_read_q   <= 1'b0;
          mem_write_q  <= 1'b0;
          mem_to_reg_q <= bus.ex_mem_to_reg;
          alu_q        <= bus.ex_alu_result;
          wdata_q      <= bus.ex_rt_data;
          wreg_q       <= bus.ex_write_reg;
          pc_src_q     <= taken;
          flush_q      <= taken;
          if (taken) begin
            branch_pc_q <= bus.ex_branch_target;
          end
          retire_q <= retire_q + 32'd1;
        end else if (accept && ovf_trap) begin
          valid_q      <= 1'b0;
          reg_write_q  <= 1'b0;
          mem_read_q   <= 1'b0;
          mem_write_q  <= 1'b0;
          mem_to_reg_q <= 1'b0;
          epc_q        <= bus.ex_pc_plus4 - DW'(4);
          ovf_q        <= 1'b1;
          flush_q      <= 1'b1;
          state_q      <= TRAP;
        end else if (accept) begin
          valid_q      <= 1'b1;
          reg_write_q  <= bus.ex_reg_write;
          mem_read_q   <= bus.ex_mem_read;
          mem_write_q  <= bus.ex_mem_write;
          mem_to_reg_q <= bus.ex_mem_to_reg;
          alu_q        <= bus.ex_alu_result;
          wdata_q      <= bus.ex_rt_data;
          wreg_q       <= bus.ex_write_reg;
          retire_q     <= retire_q + 32'd1;
        end else begin
          valid_q      <= 1'b0;
          reg_write_q  <= 1'b0;
          mem_read_q   <= 1'b0;
          mem_write_q  <= 1'b0;
          mem_to_reg_q <= 1'b0;
        end
        if (state_q == TRAP && bus.trap_ack) begin
          state_q <= RUN;
          ovf_q   <= 1'b0;
        end
      end
    end
  end

  assign bus.ex_ready       = ~bus.mem_stall;
  assign bus.mem_valid      = valid_q;
  assign bus.mem_reg_write  = reg_write_q;
  assign bus.mem_mem_read   = mem_read_q;
  assign bus.mem_mem_write  = mem_write_q;
  assign bus.mem_mem_to_reg = mem_to_reg_q;
  assign bus.mem_alu_result = alu_q;
  assign bus.mem_write_data = wdata_q;
  assign bus.mem_write_reg  = wreg_q;
  assign bus.pc_src         = pc_src_q;
  assign bus.branch_pc      = branch_pc_q;
  assign bus.flush_upstream = flush_q;
  assign bus.ovf_exception  = ovf_q;
  assign bus.epc            = epc_q;
  assign bus.retire_count   = retire_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed testbench for ex_mem_reg: add, branches, stall hold,
// overflow trap, unsigned overflow, counter wrap, reset in TRAP.
module tb_ex_mem_reg;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  ex_mem_if #(.DW(32), .RW(5)) bus ();

  ex_mem_reg #(.DW(32), .RW(5)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.ex_valid         = 1'b0;
    bus.ex_alu_result    = '0;
    bus.ex_zero          = 1'b0;
    bus.ex_overflow      = 1'b0;
    bus.ex_rt_data       = '0;
    bus.ex_write_reg     = '0;
    bus.ex_pc_plus4      = '0;
    bus.ex_branch_target = '0;
    bus.ex_reg_write     = 1'b0;
    bus.ex_mem_read      = 1'b0;
    bus.ex_mem_write     = 1'b0;
    bus.ex_mem_to_reg    = 1'b0;
    bus.ex_branch        = 1'b0;
    bus.ex_branch_ne     = 1'b0;
    bus.ex_trap_ovf      = 1'b0;
  endtask

  initial begin
    clr();
    bus.mem_stall = 1'b0;
    bus.trap_ack  = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    chk("rst_valid", 32'(bus.mem_valid), 0);
    chk("rst_retire", bus.retire_count, 0);
    chk("rst_ovf", 32'(bus.ovf_exception), 0);
    chk("rst_pcsrc", 32'(bus.pc_src), 0);
    chk("rst_ready", 32'(bus.ex_ready), 1);
    rst_n = 1'b1;

    // plain add
    bus.ex_valid = 1'b1;
    bus.ex_alu_result = 32'h5;
    bus.ex_reg_write = 1'b1;
    bus.ex_write_reg = 5'd3;
    step();
    chk("add_valid", 32'(bus.mem_valid), 1);
    chk("add_alu", bus.mem_alu_result, 32'h5);
    chk("add_wreg", 32'(bus.mem_write_reg), 3);
    chk("add_rw", 32'(bus.mem_reg_write), 1);
    chk("add_retire", bus.retire_count, 1);

    // beq taken
    bus.ex_branch = 1'b1;
    bus.ex_branch_ne = 1'b0;
    bus.ex_zero = 1'b1;
    bus.ex_branch_target = 32'h40;
    step();
    chk("beq_pcsrc", 32'(bus.pc_src), 1);
    chk("beq_bpc", bus.branch_pc, 32'h40);
    chk("beq_flush", 32'(bus.flush_upstream), 1);
    chk("beq_rw", 32'(bus.mem_reg_write), 0);
    chk("beq_valid", 32'(bus.mem_valid), 1);
    chk("beq_retire", bus.retire_count, 2);
    clr();
    step();
    chk("beq_pcsrc_off", 32'(bus.pc_src), 0);
    chk("beq_flush_off", 32'(bus.flush_upstream), 0);
    chk("bubble_valid", 32'(bus.mem_valid), 0);

    // bne with zero=1: not taken
    bus.ex_valid = 1'b1;
    bus.ex_branch = 1'b1;
    bus.ex_branch_ne = 1'b1;
    bus.ex_zero = 1'b1;
    bus.ex_branch_target = 32'h80;
    step();
    chk("bne_pcsrc", 32'(bus.pc_src), 0);
    chk("bne_valid", 32'(bus.mem_valid), 1);
    chk("bne_retire", bus.retire_count, 3);

    // load then stall for 3 cycles
    clr();
    bus.ex_valid = 1'b1;
    bus.ex_mem_read = 1'b1;
    bus.ex_mem_to_reg = 1'b1;
    bus.ex_reg_write = 1'b1;
    bus.ex_alu_result = 32'h100;
    bus.ex_write_reg = 5'd7;
    step();
    chk("ld_alu", bus.mem_alu_result, 32'h100);
    chk("ld_retire", bus.retire_count, 4);
    bus.mem_stall = 1'b1;
    bus.ex_alu_result = 32'h200;
    bus.ex_write_reg = 5'd9;
    bus.ex_mem_read = 1'b0;
    #1;
    chk("stall_ready", 32'(bus.ex_ready), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_alu", bus.mem_alu_result, 32'h100);
      chk("stall_wreg", 32'(bus.mem_write_reg), 7);
      chk("stall_rd", 32'(bus.mem_mem_read), 1);
      chk("stall_retire", bus.retire_count, 4);
    end
    bus.mem_stall = 1'b0;
    step();
    chk("rel_alu", bus.mem_alu_result, 32'h200);
    chk("rel_wreg", 32'(bus.mem_write_reg), 9);
    chk("rel_retire", bus.retire_count, 5);

    // unsigned overflow writes normally
    clr();
    bus.ex_valid = 1'b1;
    bus.ex_overflow = 1'b1;
    bus.ex_reg_write = 1'b1;
    bus.ex_alu_result = 32'hDEAD;
    step();
    chk("uovf_valid", 32'(bus.mem_valid), 1);
    chk("uovf_alu", bus.mem_alu_result, 32'hDEAD);
    chk("uovf_exc", 32'(bus.ovf_exception), 0);
    chk("uovf_retire", bus.retire_count, 6);

    // trapping overflow
    bus.ex_trap_ovf = 1'b1;
    bus.ex_pc_plus4 = 32'h104;
    step();
    chk("trap_valid", 32'(bus.mem_valid), 0);
    chk("trap_rw", 32'(bus.mem_reg_write), 0);
    chk("trap_epc", bus.epc, 32'h100);
    chk("trap_exc", 32'(bus.ovf_exception), 1);
    chk("trap_flush", 32'(bus.flush_upstream), 1);
    chk("trap_retire", bus.retire_count, 6);
    clr();
    bus.ex_valid = 1'b1;
    bus.ex_reg_write = 1'b1;
    bus.ex_alu_result = 32'h11;
    step();
    chk("intrap_valid", 32'(bus.mem_valid), 0);
    chk("intrap_exc", 32'(bus.ovf_exception), 1);
    chk("intrap_flush", 32'(bus.flush_upstream), 0);
    chk("intrap_epc", bus.epc, 32'h100);
    chk("intrap_ready", 32'(bus.ex_ready), 1);
    bus.trap_ack = 1'b1;
    step();
    chk("ack_valid", 32'(bus.mem_valid), 0);
    chk("ack_exc", 32'(bus.ovf_exception), 0);
    chk("ack_retire", bus.retire_count, 6);
    bus.trap_ack = 1'b0;
    step();
    chk("resume_valid", 32'(bus.mem_valid), 1);
    chk("resume_alu", bus.mem_alu_result, 32'h11);
    chk("resume_retire", bus.retire_count, 7);

    // counter wrap from preloaded all-ones
    bus.ex_valid = 1'b0;
    step();
    force dut.retire_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_q;
    chk("preload", bus.retire_count, 32'hFFFF_FFFF);
    bus.ex_valid = 1'b1;
    step();
    chk("wrap_retire", bus.retire_count, 0);
    chk("wrap_valid", 32'(bus.mem_valid), 1);

    // reset while in TRAP and stalled
    bus.ex_trap_ovf = 1'b1;
    bus.ex_overflow = 1'b1;
    bus.ex_pc_plus4 = 32'h8;
    step();
    chk("trap2_epc", bus.epc, 32'h4);
    chk("trap2_exc", 32'(bus.ovf_exception), 1);
    bus.mem_stall = 1'b1;
    rst_n = 1'b0;
    step();
    chk("rst2_valid", 32'(bus.mem_valid), 0);
    chk("rst2_exc", 32'(bus.ovf_exception), 0);
    chk("rst2_epc", bus.epc, 0);
    chk("rst2_alu", bus.mem_alu_result, 0);
    chk("rst2_bpc", bus.branch_pc, 0);
    chk("rst2_retire", bus.retire_count, 0);
    rst_n = 1'b1;
    bus.mem_stall = 1'b0;
    clr();
    bus.ex_valid = 1'b1;
    bus.ex_alu_result = 32'h33;
    step();
    chk("rst2_run_valid", 32'(bus.mem_valid), 1);
    chk("rst2_run_alu", bus.mem_alu_result, 32'h33);
    chk("rst2_run_retire", bus.retire_count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
